// File: rtl/instr_fetch_unit_pkg.sv
// Shared RISC pipeline definitions: opcode encodings, instruction field
// positions, bubble encoding and the fetch state enum. Decode and the hazard
// unit reuse these.
package riscPkg;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

  localparam logic [5:0] OP_JUMP = 6'b010101;
  localparam logic [5:0] OP_BRA  = 6'b010110;

  // Encoding used for bubbles and flushed slots.
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle between the fetch unit and its surroundings: instruction-memory
// address/data, hazard and branch inputs, IF/ID register outputs, status.
//
// Transfer rule: ifid_instr/ifid_pc carry a real instruction exactly when
// ifid_valid is 1; with ifid_valid 0 the slot is a bubble (NOP_WORD).
// stall is the only backpressure: while it is 1 (and no br_taken) the IF/ID
// register and PC hold, so decode sees the same slot again. br_taken is a
// one-cycle command qualified by itself; br_target is only looked at then.
interface instr_fetch_unit_if;
  import riscPkg::*;

  logic [31:0]  imem_addr;
  logic [31:0]  imem_data;
  logic         stall;
  logic         br_taken;
  logic [31:0]  br_target;
  logic [31:0]  ifid_instr;
  logic [31:0]  ifid_pc;
  logic         ifid_valid;
  logic         halted;
  logic [31:0]  fetch_count;
  fetch_state_t state;

  // Fetch unit side.
  modport master (
    output imem_addr,
    input  imem_data,
    input  stall,
    input  br_taken,
    input  br_target,
    output ifid_instr,
    output ifid_pc,
    output ifid_valid,
    output halted,
    output fetch_count,
    output state
  );

  // Memory / pipeline side.
  modport slave (
    input  imem_addr,
    output imem_data,
    output stall,
    output br_taken,
    output br_target,
    input  ifid_instr,
    input  ifid_pc,
    input  ifid_valid,
    input  halted,
    input  fetch_count,
    input  state
  );

endinterface

// File: rtl/instr_fetch_unit_predecode.sv
// Combinational predecode of the fetched word: spots unconditional jumps so
// the PC can be redirected in the same cycle the jump is fetched.
module fetch_predecode
  import riscPkg::OP_JUMP;
(
  input  logic [5:0]  opcode,
  input  logic [15:0] imm16,
  output logic        is_jump,
  output logic [31:0] jump_target
);

  // Jump target is the zero-extended 16-bit word index.
  always_comb begin
    is_jump     = (opcode == OP_JUMP);
    jump_target = {16'h0000, imm16};
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses the combinational
// instruction memory, loads the IF/ID register, and handles stalls, taken
// branches (one-bubble flush) and predecoded jumps (zero bubbles).
module instr_fetch_unit
  import riscPkg::fetch_state_t, riscPkg::RUN, riscPkg::HALT,
         riscPkg::OPCODE_MSB, riscPkg::OPCODE_LSB,
         riscPkg::IMM_MSB, riscPkg::IMM_LSB;
#(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter int          IMEM_DEPTH = 32,
  parameter logic [31:0] NOP_WORD   = riscPkg::NOP_WORD
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_unit_if.master fif
);

  localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  ipc_q, ipc_d;
  logic         valid_q, valid_d;
  logic [31:0]  count_q, count_d;

  logic         is_jump;
  logic [31:0]  jump_target;
  logic         pc_oob;
  logic         advance;

  fetch_predecode u_predecode (
    .opcode      (fif.imem_data[OPCODE_MSB:OPCODE_LSB]),
    .imm16       (fif.imem_data[IMM_MSB:IMM_LSB]),
    .is_jump     (is_jump),
    .jump_target (jump_target)
  );

  assign pc_oob = (pc_q >= DEPTH_W);
  // A real fetch happens only in RUN with an in-range PC and no stall/flush.
  assign advance = !fif.br_taken && !fif.stall && (state_q == RUN) && !pc_oob;

  // State and datapath registers; reset clears immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      ipc_q   <= 32'd0;
      valid_q <= 1'b0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // Next state: a taken branch always restarts fetch; otherwise running off
  // the end of memory halts.
  always_comb begin
    state_d = state_q;
    if (fif.br_taken) begin
      state_d = RUN;
    end else if (!fif.stall && (state_q == RUN) && pc_oob) begin
      state_d = HALT;
    end
  end

  // Datapath next values in priority order: branch, stall, halt, out of
  // range, jump, sequential.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    count_d = count_q;
    if (fif.br_taken) begin
      pc_d    = fif.br_target;
      instr_d = NOP_WORD;
      valid_d = 1'b0;
    end else if (fif.stall) begin
      // hold everything
    end else if ((state_q == HALT) || pc_oob) begin
      instr_d = NOP_WORD;
      valid_d = 1'b0;
    end else begin
      instr_d = fif.imem_data;
      ipc_d   = pc_q;
      valid_d = 1'b1;
      pc_d    = is_jump ? jump_target : (pc_q + 32'd1);
    end
    if (advance && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end
  end

  // Outputs are straight register views; memory address is the live PC.
  always_comb begin
    fif.imem_addr   = pc_q;
    fif.ifid_instr  = instr_q;
    fif.ifid_pc     = ipc_q;
    fif.ifid_valid  = valid_q;
    fif.halted      = (state_q == HALT);
    fif.fetch_count = count_q;
    fif.state       = state_q;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a combinational memory model.
module tb_instr_fetch_unit;
  import riscPkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [31:0] mem [0:63];

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .RESET_PC   (32'd0),
    .IMEM_DEPTH (32),
    .NOP_WORD   (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .fif (bus.master)
  );

  // Same-cycle memory read.
  assign bus.imem_data = (bus.imem_addr < 32'd64) ? mem[bus.imem_addr[5:0]] : 32'h0;

  // Clock: rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_addr"},  bus.imem_addr, 32'd0);
    chk({tag, "_instr"}, bus.ifid_instr, 32'h0);
    chk({tag, "_pc"},    bus.ifid_pc, 32'd0);
    chk({tag, "_valid"}, {31'd0, bus.ifid_valid}, 32'd0);
    chk({tag, "_halt"},  {31'd0, bus.halted}, 32'd0);
    chk({tag, "_count"}, bus.fetch_count, 32'd0);
    chk({tag, "_state"}, {31'd0, bus.state}, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0800_0000 | i;
    mem[0]  = 32'h1001_0064;
    mem[1]  = 32'h4c1e_0001;
    mem[4]  = 32'h4422_0001;
    mem[5]  = 32'h0000_0000;
    mem[8]  = 32'h0422_1800;
    mem[15] = 32'h5400_0015;
    mem[21] = 32'h0ca0_00c9;

    rst           = 1'b1;
    bus.stall     = 1'b0;
    bus.br_taken  = 1'b0;
    bus.br_target = 32'd0;
    #2;
    chk_reset_values("rst");
    #6 rst = 1'b0;

    // First two fetches after reset.
    step();
    chk("f0_instr", bus.ifid_instr, 32'h1001_0064);
    chk("f0_pc",    bus.ifid_pc, 32'd0);
    chk("f0_valid", {31'd0, bus.ifid_valid}, 32'd1);
    chk("f0_addr",  bus.imem_addr, 32'd1);
    step();
    chk("f1_instr", bus.ifid_instr, 32'h4c1e_0001);
    chk("f1_pc",    bus.ifid_pc, 32'd1);
    chk("f1_count", bus.fetch_count, 32'd2);

    // Run to pc=8, then stall three cycles.
    steps(6);
    chk("pre_stall_addr", bus.imem_addr, 32'd8);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_addr",  bus.imem_addr, 32'd8);
      chk("stall_pc",    bus.ifid_pc, 32'd7);
      chk("stall_instr", bus.ifid_instr, 32'h0800_0007);
      chk("stall_count", bus.fetch_count, 32'd8);
    end
    bus.stall = 1'b0;
    step();
    chk("unstall_instr", bus.ifid_instr, 32'h0422_1800);
    chk("unstall_pc",    bus.ifid_pc, 32'd8);
    chk("unstall_count", bus.fetch_count, 32'd9);

    // Branch at pc=11 overriding a stall.
    steps(2);
    chk("pre_br_addr", bus.imem_addr, 32'd11);
    bus.stall     = 1'b1;
    bus.br_taken  = 1'b1;
    bus.br_target = 32'd5;
    step();
    bus.stall    = 1'b0;
    bus.br_taken = 1'b0;
    chk("br_valid", {31'd0, bus.ifid_valid}, 32'd0);
    chk("br_instr", bus.ifid_instr, 32'h0);
    chk("br_addr",  bus.imem_addr, 32'd5);
    chk("br_count", bus.fetch_count, 32'd11);
    step();
    chk("br_tgt_pc",    bus.ifid_pc, 32'd5);
    chk("br_tgt_instr", bus.ifid_instr, 32'h0);
    chk("br_tgt_valid", {31'd0, bus.ifid_valid}, 32'd1);
    chk("br_tgt_count", bus.fetch_count, 32'd12);

    // Jump at word 15 to word 21, no bubble.
    steps(9);
    chk("pre_jmp_addr", bus.imem_addr, 32'd15);
    step();
    chk("jmp_instr", bus.ifid_instr, 32'h5400_0015);
    chk("jmp_pc",    bus.ifid_pc, 32'd15);
    chk("jmp_addr",  bus.imem_addr, 32'd21);
    step();
    chk("jmp_tgt_pc",    bus.ifid_pc, 32'd21);
    chk("jmp_tgt_instr", bus.ifid_instr, 32'h0ca0_00c9);
    chk("jmp_tgt_valid", {31'd0, bus.ifid_valid}, 32'd1);
    chk("jmp_tgt_count", bus.fetch_count, 32'd23);

    // Run off the end of memory.
    steps(10);
    chk("end_addr",  bus.imem_addr, 32'd32);
    chk("end_pc",    bus.ifid_pc, 32'd31);
    chk("end_halt0", {31'd0, bus.halted}, 32'd0);
    step();
    chk("halt_flag",  {31'd0, bus.halted}, 32'd1);
    chk("halt_valid", {31'd0, bus.ifid_valid}, 32'd0);
    chk("halt_instr", bus.ifid_instr, 32'h0);
    chk("halt_addr",  bus.imem_addr, 32'd32);
    chk("halt_count", bus.fetch_count, 32'd33);
    step();
    chk("halt_hold_addr", bus.imem_addr, 32'd32);
    chk("halt_hold_flag", {31'd0, bus.halted}, 32'd1);

    // Branch out of HALT to word 4.
    bus.br_taken  = 1'b1;
    bus.br_target = 32'd4;
    step();
    bus.br_taken = 1'b0;
    chk("rehalt_flag",  {31'd0, bus.halted}, 32'd0);
    chk("rehalt_valid", {31'd0, bus.ifid_valid}, 32'd0);
    chk("rehalt_addr",  bus.imem_addr, 32'd4);
    step();
    chk("w4_instr", bus.ifid_instr, 32'h4422_0001);
    chk("w4_pc",    bus.ifid_pc, 32'd4);
    chk("w4_count", bus.fetch_count, 32'd34);

    // Branch to an out-of-range target halts on the next edge.
    bus.br_taken  = 1'b1;
    bus.br_target = 32'd40;
    step();
    bus.br_taken = 1'b0;
    chk("oob_br_addr", bus.imem_addr, 32'd40);
    chk("oob_br_halt", {31'd0, bus.halted}, 32'd0);
    step();
    chk("oob_halt",  {31'd0, bus.halted}, 32'd1);
    chk("oob_count", bus.fetch_count, 32'd34);
    bus.br_taken  = 1'b1;
    bus.br_target = 32'd2;
    step();
    bus.br_taken = 1'b0;
    step();
    chk("w2_instr", bus.ifid_instr, 32'h0800_0002);
    chk("w2_count", bus.fetch_count, 32'd35);

    // Asynchronous reset between edges.
    #3 rst = 1'b1;
    #1;
    chk_reset_values("arst");
    #1 rst = 1'b0;
    step();
    chk("post_rst_instr", bus.ifid_instr, 32'h1001_0064);
    chk("post_rst_pc",    bus.ifid_pc, 32'd0);
    chk("post_rst_count", bus.fetch_count, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
